// File: rtl/fifo_word_packer.sv
// rtl/fifo_word_packer.sv - packs RATIO narrow FIFO words little-endian into wide words behind a 2-entry buffer
// Optional partial-word flush input is enabled by defining PACKER_FLUSH_EN.
module fifo_word_packer #(
    parameter int IN_WIDTH  = 8,
    parameter int RATIO     = 4,
    parameter int OUT_WIDTH = IN_WIDTH * RATIO
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_ready,
    input  logic [IN_WIDTH-1:0]         in_data,
    output logic                        in_pop,
    output logic                        out_ready,
    output logic [OUT_WIDTH-1:0]        out_data,
    input  logic                        out_pop,
`ifdef PACKER_FLUSH_EN
    input  logic                        flush,
`endif
    output logic [$clog2(RATIO+1)-1:0]  out_count
);

    localparam int CW  = $clog2(RATIO);
    localparam int OCW = $clog2(RATIO + 1);
    localparam logic [CW-1:0]  LAST_SLOT = CW'(RATIO - 1);
    localparam logic [OCW-1:0] FULL_CNT  = OCW'(RATIO);

    logic [CW-1:0]        cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0] acc_q, acc_d;
    logic [OUT_WIDTH-1:0] ent_data_q [2];
    logic [OUT_WIDTH-1:0] ent_data_d [2];
    logic [OCW-1:0]       ent_cnt_q [2];
    logic [OCW-1:0]       ent_cnt_d [2];
    logic [1:0]           entries_q, entries_d;

    logic                 at_last;
    logic                 buf_full;
    logic                 accept;
    logic                 rd_en;
    logic                 wr_en;
    logic [OUT_WIDTH-1:0] wr_data;
    logic [OCW-1:0]       wr_count;

    assign at_last   = (cnt_q == LAST_SLOT);
    assign buf_full  = (entries_q == 2'd2);
    assign accept    = !at_last || !buf_full;
    // Gated by rst_n so the FIFO never sees a pop while the packer is held in reset.
    assign in_pop    = in_ready && accept && rst_n;
    assign out_ready = (entries_q != 2'd0);
    assign out_data  = ent_data_q[0];
    assign out_count = ent_cnt_q[0];
    assign rd_en     = out_pop && out_ready;

    // Slots below cnt come from the accumulator, slot cnt from the word popped this
    // cycle, and everything above is zero (only reachable on a flush).
    always_comb begin
        wr_data = '0;
        acc_d   = acc_q;
        for (int s = 0; s < RATIO; s++) begin
            if (CW'(s) < cnt_q) begin
                wr_data[s*IN_WIDTH +: IN_WIDTH] = acc_q[s*IN_WIDTH +: IN_WIDTH];
            end else if ((CW'(s) == cnt_q) && in_pop) begin
                wr_data[s*IN_WIDTH +: IN_WIDTH] = in_data;
                acc_d[s*IN_WIDTH +: IN_WIDTH]   = in_data;
            end
        end
    end

`ifdef PACKER_FLUSH_EN
    logic flush_pend_q, flush_pend_d;
    logic flush_req;
    logic flush_go;

    assign flush_req = flush || flush_pend_q;
    assign flush_go  = flush_req && !buf_full && (cnt_q != '0);

    always_comb begin
        flush_pend_d = flush_req && buf_full && ((cnt_q != '0) || in_pop);
        wr_en        = (in_pop && at_last) || flush_go;
        if (in_pop && at_last) begin
            wr_count = FULL_CNT;
        end else if (in_pop) begin
            wr_count = OCW'(cnt_q) + OCW'(1);
        end else begin
            wr_count = OCW'(cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_pend_q <= 1'b0;
        end else begin
            flush_pend_q <= flush_pend_d;
        end
    end
`else
    always_comb begin
        wr_en    = in_pop && at_last;
        wr_count = FULL_CNT;
    end
`endif

    always_comb begin
        cnt_d = cnt_q;
        if (wr_en) begin
            cnt_d = '0;
        end else if (in_pop) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Entry 0 is always the head; entries shift down on a pop.
    always_comb begin
        ent_data_d[0] = ent_data_q[0];
        ent_data_d[1] = ent_data_q[1];
        ent_cnt_d[0]  = ent_cnt_q[0];
        ent_cnt_d[1]  = ent_cnt_q[1];
        entries_d     = entries_q;
        case ({wr_en, rd_en})
            2'b10: begin
                ent_data_d[entries_q[0]] = wr_data;
                ent_cnt_d[entries_q[0]]  = wr_count;
                entries_d                = entries_q + 2'd1;
            end
            2'b01: begin
                ent_data_d[0] = ent_data_q[1];
                ent_cnt_d[0]  = ent_cnt_q[1];
                entries_d     = entries_q - 2'd1;
            end
            2'b11: begin
                if (buf_full) begin
                    ent_data_d[0] = ent_data_q[1];
                    ent_cnt_d[0]  = ent_cnt_q[1];
                    ent_data_d[1] = wr_data;
                    ent_cnt_d[1]  = wr_count;
                end else begin
                    ent_data_d[0] = wr_data;
                    ent_cnt_d[0]  = wr_count;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            acc_q         <= '0;
            entries_q     <= '0;
            ent_data_q[0] <= '0;
            ent_data_q[1] <= '0;
            ent_cnt_q[0]  <= '0;
            ent_cnt_q[1]  <= '0;
        end else begin
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            entries_q     <= entries_d;
            ent_data_q[0] <= ent_data_d[0];
            ent_data_q[1] <= ent_data_d[1];
            ent_cnt_q[0]  <= ent_cnt_d[0];
            ent_cnt_q[1]  <= ent_cnt_d[1];
        end
    end

endmodule
